// File: rtl/divide_pkg.sv
// Shared definitions for the signed iterative divider: FSM state codes and
// the argument channel indices.
package divide_pkg;

  // Top-level FSM state encoding
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] DIVIDE  = 2'd1;
  localparam logic [1:0] FIXUP   = 2'd2;
  localparam logic [1:0] RESULT  = 2'd3;

  // Argument channel roles
  localparam int DIVIDEND = 0;
  localparam int DIVISOR  = 1;

endpackage

// File: rtl/divide_core.sv
// Unsigned restoring division datapath. One quotient bit per cycle, MSB first.
// The operands must stay stable from start until done; the top level holds
// them in its argument slots for the whole operation.
module divide_core
  import divide_pkg::*;
#(
  parameter int ARGW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ARGW-1:0] dividend,
  input  logic [ARGW:0]   divisor,
  output logic [ARGW-1:0] quotient,
  output logic [ARGW-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(ARGW);

  logic [ARGW:0]   rem;
  logic [ARGW-1:0] quo;
  logic [CW-1:0]   cnt;
  logic            busy;
  logic [ARGW+1:0] diff;

  // Trial subtraction of the divisor from the partial remainder shifted left
  // by one with the next dividend bit; diff MSB set means the trial borrowed.
  assign diff = {rem, quo[ARGW-1]} - {1'b0, divisor};

  // Strobe for the cycle whose edge performs the final iteration
  assign done      = busy && (cnt == '0);
  assign quotient  = quo;
  assign remainder = rem[ARGW-1:0];

  // Iteration registers: load on start, then shift/subtract until the count expires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      // NOTE: non-blocking (<=) for all state so each register sees the
      // pre-edge values of the others; blocking here would make the result
      // depend on statement order.
      rem  <= '0;
      quo  <= dividend;
      cnt  <= CW'(ARGW - 1);
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= diff[ARGW+1] ? {rem[ARGW-1:0], quo[ARGW-1]} : diff[ARGW:0];
      quo  <= {quo[ARGW-2:0], ~diff[ARGW+1]};
      cnt  <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/divide.sv
// Signed integer divider on valid/ready streams. Channel 0 supplies the
// dividend, channel 1 the divisor; the result is {remainder, quotient} with
// truncation toward zero and the remainder carrying the dividend's sign.
module divide
  import divide_pkg::*;
#(
  parameter  int ARGW = 16,
  parameter  int ARGC = 2,
  localparam int RESW = 2 * ARGW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ARGC-1:0]           arg_valid,
  input  logic [ARGC-1:0][ARGW-1:0] arg_data,
  output logic [ARGC-1:0]           arg_ready,
  output logic                      res_valid,
  output logic [RESW-1:0]           res_data,
  input  logic                      res_ready
);

  if (ARGC != 2) begin : g_bad_argc
    $error("divide: ARGC must be 2");
  end

  logic [1:0]                state;
  logic [ARGC-1:0]           slot_full;
  logic [ARGC-1:0][ARGW-1:0] slot;

  logic [ARGW-1:0] dvd_mag;
  logic [ARGW-1:0] dvs_mag;
  logic            dvd_neg;
  logic            quo_neg;
  logic            div_zero;
  logic            core_start;
  logic            core_done;
  logic [ARGW-1:0] core_quo;
  logic [ARGW-1:0] core_rem;

  // Magnitudes as unsigned ARGW-bit values: -2^(ARGW-1) maps to 2^(ARGW-1),
  // which an unsigned field of the same width still holds exactly.
  assign dvd_neg  = slot[DIVIDEND][ARGW-1];
  assign quo_neg  = slot[DIVIDEND][ARGW-1] ^ slot[DIVISOR][ARGW-1];
  assign dvd_mag  = dvd_neg ? -slot[DIVIDEND] : slot[DIVIDEND];
  assign dvs_mag  = slot[DIVISOR][ARGW-1] ? -slot[DIVISOR] : slot[DIVISOR];
  assign div_zero = (slot[DIVISOR] == '0);

  // A slot accepts only while collecting and still empty
  assign arg_ready = (state == COLLECT) ? ~slot_full : '0;

  // The core is launched on the same edge that enters DIVIDE; a zero divisor
  // skips the iteration entirely.
  assign core_start = (state == COLLECT) && (&slot_full) && !div_zero;

  divide_core #(.ARGW(ARGW)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .dividend  (dvd_mag),
    .divisor   ({1'b0, dvs_mag}),
    .quotient  (core_quo),
    .remainder (core_rem),
    .done      (core_done)
  );

  // Control FSM: operand capture, sequencing of the core, sign fixup and result handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      slot_full <= '0;
      slot      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          for (int i = 0; i < ARGC; i++) begin
            if (arg_valid[i] && arg_ready[i]) begin
              slot[i]      <= arg_data[i];
              slot_full[i] <= 1'b1;
            end
          end
          if (&slot_full) state <= DIVIDE;
        end
        DIVIDE: begin
          if (div_zero) begin
            res_data  <= {slot[DIVIDEND], {ARGW{1'b1}}};
            res_valid <= 1'b1;
            state     <= RESULT;
          end else if (core_done) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          res_data  <= {(dvd_neg ? -core_rem : core_rem),
                        (quo_neg ? -core_quo : core_quo)};
          res_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            slot_full <= '0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for the signed divider: reference model on plain
// integer arithmetic, a per-cycle compare process, and directed vectors with
// hand-computed results.
module tb_divide;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       arg_valid;
  logic [1:0][15:0] arg_data;
  logic [1:0]       arg_ready;
  logic             res_valid;
  logic [31:0]      res_data;
  logic             res_ready;

  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  assign arg_valid = {v1, v0};
  assign arg_data  = {d1, d0};

  divide dut (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_data  (arg_data),
    .arg_ready (arg_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;
  int          xfer_cnt = 0;
  int          xfer_cyc = 0;
  int          cap0 = -1;
  logic        rand_on = 1'b0;

  // Reference: truncating signed division, remainder follows the dividend
  function automatic logic [31:0] model(input logic signed [15:0] a,
                                        input logic signed [15:0] b);
    int ai, bi, q, r;
    ai = a;
    bi = b;
    if (bi == 0) return {a, 16'hFFFF};
    q = ai / bi;
    r = ai % bi;
    return {r[15:0], q[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic [15:0] d);
    if (ch == 0) begin
      v0 = v;
      d0 = d;
    end else begin
      v1 = v;
      d1 = d;
    end
  endtask

  // Offer one argument and return the cycle number of the capturing edge
  task automatic send(input int ch, input logic [15:0] d, output int cap);
    int n;
    n   = 0;
    cap = -1;
    drive(ch, 1'b1, d);
    @(negedge clk);
    while (!arg_ready[ch] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (arg_ready[ch]) begin
      @(posedge clk);
      #1;
      cap = cyc;
    end else begin
      fail("arg_ready_timeout", $sformatf("channel %0d never accepted", ch));
    end
    drive(ch, 1'b0, d);
  endtask

  task automatic wait_valid(input int c0, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (res_valid) lat = cyc - c0;
    else begin
      lat = -1;
      fail("res_valid_timeout", "no result within 100 cycles");
    end
  endtask

  task automatic wait_xfer(input int target);
    int n;
    n = 0;
    while (xfer_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (xfer_cnt < target) fail("res_xfer_timeout", "result never transferred");
    else step();
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] lit, input int exp_lat);
    int cd, c0, lat, tgt;
    tgt = xfer_cnt + 1;
    exp_q.push_back(model(a, b));
    send(0, a, cd);
    send(1, b, c0);
    wait_valid(c0, lat);
    if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
    wait_xfer(tgt);
    check({name, "_result"}, last_res, lit);
  endtask

  // Divisor first, dividend 5 cycles later, result collected concurrently
  task automatic fork_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] lit);
    int ca, cb, tgt;
    tgt = xfer_cnt + 1;
    exp_q.push_back(model(a, b));
    fork
      begin
        send(1, b, cb);
        repeat (5) step();
        send(0, a, ca);
      end
      begin
        wait_xfer(tgt);
      end
    join
    check({name, "_result"}, last_res, lit);
  endtask

  // Compare process: every cycle a result is offered it must match the model
  logic prev_v = 1'b0, prev_r = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) check("res_valid_held", res_valid, 1);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          fail("res_unexpected", $sformatf("res_data=%h with nothing outstanding", res_data));
        end else begin
          check("res_data_vs_model", res_data, exp_q[0]);
          if (res_ready) begin
            last_res = res_data;
            xfer_cnt++;
            xfer_cyc = cyc + 1;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_v = res_valid;
      prev_r = res_ready;
    end
  end

  // Timeout watchdog
  initial begin
    repeat (1_000_000) @(posedge clk);
    n_bad++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_res_valid", res_valid, 0);
    check("reset_arg_ready", arg_ready, 2'b11);
    check("reset_res_data", res_data, 32'h0);
    rst = 1'b0;
    step();

    // Sequential arguments, latency of a full iteration
    res_ready = 1'b1;
    do_op("div_100_7", 16'd100, 16'd7, 32'h0002_000E, 18);

    // Out-of-order arrival with a gap, sign combinations
    fork_op("neg100_7", 16'(-100), 16'd7, 32'hFFFE_FFF2);
    fork_op("100_neg7", 16'd100, 16'(-7), 32'h0002_FFF2);
    fork_op("neg100_neg7", 16'(-100), 16'(-7), 32'hFFFE_000E);

    // Boundaries
    do_op("div_5_0", 16'd5, 16'd0, 32'h0005_FFFF, 2);
    do_op("min_neg1", 16'h8000, 16'hFFFF, 32'h0000_8000, 18);
    do_op("div_0_3", 16'd0, 16'd3, 32'h0000_0000, 18);

    // Result backpressure with a pending dividend held off
    begin
      int cd, c0, c1, lat, tgt, x1;
      logic [31:0] held;
      res_ready = 1'b0;
      tgt = xfer_cnt + 1;
      exp_q.push_back(model(16'd1234, 16'(-56)));
      send(0, 16'd1234, cd);
      send(1, 16'(-56), c0);
      wait_valid(c0, lat);
      held = res_data;
      exp_q.push_back(model(16'(-300), 16'd7));
      cap0 = -1;
      fork
        send(0, 16'(-300), cap0);
      join_none
      repeat (10) begin
        @(negedge clk);
        check("bp_res_valid", res_valid, 1);
        check("bp_res_stable", res_data, held);
        check("bp_arg_ready", arg_ready, 2'b00);
      end
      step();
      res_ready = 1'b1;
      wait_xfer(tgt);
      x1 = xfer_cyc;
      check("bp_result", last_res, 32'h0002_FFEA);
      send(1, 16'd7, c1);
      wait fork;
      check("bp_pending_after_xfer", (cap0 > x1), 1);
      wait_xfer(tgt + 1);
      check("bp_next_result", last_res, 32'hFFFA_FFD6);
    end

    // Asynchronous reset in the middle of an iteration, then partial discard
    begin
      int cd, c0;
      exp_q.push_back(model(16'd12345, 16'd67));
      send(0, 16'd12345, cd);
      send(1, 16'd67, c0);
      repeat (9) step();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_res_valid", res_valid, 0);
      check("async_rst_arg_ready", arg_ready, 2'b11);
      check("async_rst_res_data", res_data, 32'h0);
      exp_q.delete();
      step();
      rst = 1'b0;
      step();
      send(0, 16'd777, cd);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("partial_discard_arg_ready", arg_ready, 2'b11);
      do_op("after_rst_1000_10", 16'd1000, 16'd10, 32'h0000_0064, 18);
    end

    // Random signed pairs with random arrival skew and random result backpressure
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 1000 && n_bad <= 20; k++) begin
          automatic logic [15:0] a, b;
          automatic int da, db, ca, cb;
          a = 16'($urandom);
          if (k % 2 == 0) b = 16'($urandom_range(1, 20));
          else            b = 16'($urandom);
          if ($urandom_range(0, 1) == 1) b = -b;
          if (b == 16'd0) b = 16'd1;
          da = $urandom_range(0, 3);
          db = $urandom_range(0, 3);
          exp_q.push_back(model(a, b));
          fork
            begin
              repeat (da) step();
              send(0, a, ca);
            end
            begin
              repeat (db) step();
              send(1, b, cb);
            end
          join
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          step();
          if (rand_on) res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
    join

    // Drain outstanding results
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) fail("drain_timeout", $sformatf("%0d results outstanding", exp_q.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
